// File: rtl/dmem_pkg.sv
// Shared types, funct3 codes and helpers for the data-memory responder.
package dmem_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Request fields captured at the accept edge
  typedef struct packed {
    logic            we;
    logic [2:0]      funct3;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } dmem_req_t;

  // Stores only know B/H/W; loads additionally allow the unsigned forms
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    logic sized;
    sized = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (we) return !sized;
    return !(sized || (f3 == F3_BU) || (f3 == F3_HU));
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel between the core LSU and the data-memory responder.
interface dmem_responder_if;
  import dmem_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_array.sv
// Word-organised RAM with per-byte write enables and a registered read port.
module dmem_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Byte-lane writes and synchronous read; contents are intentionally not reset
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: fixed-latency access with alignment/range checking and load extension.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_responder_if.slave   bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  dmem_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dmem_req_t        req_q, req_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;

  logic             commit_c;
  logic             acc_err_c;
  logic [3:0]       be_c;
  logic [XLEN-1:0]  lane_wdata_c;
  logic [XLEN-1:0]  load_ext_c;
  logic [7:0]       byte_c;
  logic [15:0]      half_c;
  logic [3:0]       arr_we_c;
  logic             arr_re_c;
  logic [AW-1:0]    arr_raddr_c;
  logic [XLEN-1:0]  arr_rdata;

  // The read is issued from the accept edge onward, so the word is ready by the commit edge
  assign arr_re_c    = ((state_q == IDLE) && bus.req_valid) || (state_q == WAIT);
  assign arr_raddr_c = (state_q == IDLE) ? bus.req_addr[AW+1:2] : req_q.addr[AW+1:2];
  // Gating on rst_n keeps a store from landing when reset coincides with the commit edge
  assign arr_we_c    = (commit_c && req_q.we && !acc_err_c && rst_n) ? be_c : 4'b0000;

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
    .clk     (clk),
    .we_i    (arr_we_c),
    .waddr_i (req_q.addr[AW+1:2]),
    .wdata_i (lane_wdata_c),
    .re_i    (arr_re_c),
    .raddr_i (arr_raddr_c),
    .rdata_o (arr_rdata)
  );

  // Access legality: funct3, natural alignment and word range
  always_comb begin
    acc_err_c = f3_illegal(req_q.we, req_q.funct3);
    if (((req_q.funct3 == F3_H) || (req_q.funct3 == F3_HU)) && req_q.addr[0]) acc_err_c = 1'b1;
    if ((req_q.funct3 == F3_W) && (req_q.addr[1:0] != 2'b00)) acc_err_c = 1'b1;
    if (req_q.addr[XLEN-1:2] >= 30'(DEPTH_WORDS)) acc_err_c = 1'b1;
  end

  // Byte-lane enables and replicated store data
  always_comb begin
    case (req_q.funct3[1:0])
      2'b00: begin
        be_c         = 4'b0001 << req_q.addr[1:0];
        lane_wdata_c = {4{req_q.wdata[7:0]}};
      end
      2'b01: begin
        be_c         = req_q.addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata_c = {2{req_q.wdata[15:0]}};
      end
      default: begin
        be_c         = 4'b1111;
        lane_wdata_c = req_q.wdata;
      end
    endcase
  end

  // Lane extraction and sign/zero extension of load data
  always_comb begin
    case (req_q.addr[1:0])
      2'b00:   byte_c = arr_rdata[7:0];
      2'b01:   byte_c = arr_rdata[15:8];
      2'b10:   byte_c = arr_rdata[23:16];
      default: byte_c = arr_rdata[31:24];
    endcase
    half_c = req_q.addr[1] ? arr_rdata[31:16] : arr_rdata[15:0];
    case (req_q.funct3)
      F3_B:    load_ext_c = {{24{byte_c[7]}}, byte_c};
      F3_H:    load_ext_c = {{16{half_c[15]}}, half_c};
      F3_BU:   load_ext_c = {24'h0, byte_c};
      F3_HU:   load_ext_c = {16'h0, half_c};
      default: load_ext_c = arr_rdata;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    commit_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          req_d   = '{we: bus.req_we, funct3: bus.req_funct3,
                      addr: bus.req_addr, wdata: bus.req_wdata};
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          commit_c    = 1'b1;
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = acc_err_c;
          rsp_rdata_d = (acc_err_c || req_q.we) ? '0 : load_ext_c;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH_WORDS=1024, LATENCY=2).
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  dmem_responder_if bus ();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction: issue, measure latency, optionally stall the response, handshake
  task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                      input logic [31:0] exp_rdata, input logic exp_err);
    int lat;
    check({tag, "/req_ready_idle"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.rsp_ready  = (hold == 0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check({tag, "/req_ready_busy"}, 32'(bus.req_ready), 32'd0);
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "/latency"}, 32'(lat), 32'(LAT));
    check({tag, "/rdata"}, bus.rsp_rdata, exp_rdata);
    check({tag, "/err"}, 32'(bus.rsp_err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "/stall_valid"}, 32'(bus.rsp_valid), 32'd1);
      check({tag, "/stall_rdata"}, bus.rsp_rdata, exp_rdata);
      check({tag, "/stall_req_ready"}, 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "/valid_after_hs"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "/rdata_held"}, bus.rsp_rdata, exp_rdata);
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = F3_W;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.rsp_ready  = 1'b1;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("rst/req_ready", 32'(bus.req_ready), 32'd1);
    check("rst/rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst/rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst/rsp_err",   32'(bus.rsp_err), 32'd0);
    rst_n = 1'b1;

    // Word store/load
    xact("sw10",  1'b1, F3_W, 32'h10, 32'hDEADBEEF, 0, 32'h0, 1'b0);
    xact("lw10",  1'b0, F3_W, 32'h10, 32'h0, 0, 32'hDEADBEEF, 1'b0);

    // Byte store and extension
    xact("sb11",  1'b1, F3_B,  32'h11, 32'h12345680, 0, 32'h0, 1'b0);
    xact("lb11",  1'b0, F3_B,  32'h11, 32'h0, 0, 32'hFFFFFF80, 1'b0);
    xact("lbu11", 1'b0, F3_BU, 32'h11, 32'h0, 0, 32'h00000080, 1'b0);
    xact("lw10b", 1'b0, F3_W,  32'h10, 32'h0, 0, 32'hDEAD80EF, 1'b0);
    xact("lb10",  1'b0, F3_B,  32'h10, 32'h0, 0, 32'hFFFFFFEF, 1'b0);
    xact("lh12",  1'b0, F3_H,  32'h12, 32'h0, 0, 32'hFFFFDEAD, 1'b0);
    xact("lhu12", 1'b0, F3_HU, 32'h12, 32'h0, 0, 32'h0000DEAD, 1'b0);
    xact("sh12",  1'b1, F3_H,  32'h12, 32'hAAAA1234, 0, 32'h0, 1'b0);
    xact("lw10c", 1'b0, F3_W,  32'h10, 32'h0, 0, 32'h123480EF, 1'b0);
    xact("lb13",  1'b0, F3_B,  32'h13, 32'h0, 0, 32'h00000012, 1'b0);

    // Last valid word
    xact("swtop", 1'b1, F3_W, 32'hFFC, 32'hA5A55A5A, 0, 32'h0, 1'b0);
    xact("lwtop", 1'b0, F3_W, 32'hFFC, 32'h0, 0, 32'hA5A55A5A, 1'b0);

    // Errors: misaligned, out of range, illegal funct3; memory untouched
    xact("sw0",      1'b1, F3_W,   32'h0,    32'h0BADF00D, 0, 32'h0, 1'b0);
    xact("lw13",     1'b0, F3_W,   32'h13,   32'h0, 0, 32'h0, 1'b1);
    xact("sh1001",   1'b1, F3_H,   32'h1001, 32'h0000FFFF, 0, 32'h0, 1'b1);
    xact("lw0",      1'b0, F3_W,   32'h0,    32'h0, 0, 32'h0BADF00D, 1'b0);
    xact("sh11",     1'b1, F3_H,   32'h11,   32'h0000FFFF, 0, 32'h0, 1'b1);
    xact("lw10d",    1'b0, F3_W,   32'h10,   32'h0, 0, 32'h123480EF, 1'b0);
    xact("lwdepth",  1'b0, F3_W,   32'(4*DEPTH), 32'h0, 0, 32'h0, 1'b1);
    xact("sbu_st",   1'b1, F3_BU,  32'h10,   32'h00000000, 0, 32'h0, 1'b1);
    xact("ld_f3_3",  1'b0, 3'b011, 32'h10,   32'h0, 0, 32'h0, 1'b1);
    xact("lw10e",    1'b0, F3_W,   32'h10,   32'h0, 0, 32'h123480EF, 1'b0);

    // Response backpressure
    xact("bp_lw10",  1'b0, F3_W, 32'h10, 32'h0, 5, 32'h123480EF, 1'b0);
    xact("bp_next",  1'b0, F3_HU, 32'h10, 32'h0, 0, 32'h000080EF, 1'b0);

    // Reset during WAIT discards the pending store
    xact("sw20",  1'b1, F3_W, 32'h20, 32'hCAFEF00D, 0, 32'h0, 1'b0);
    xact("lw20",  1'b0, F3_W, 32'h20, 32'h0, 0, 32'hCAFEF00D, 1'b0);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = F3_W;
    bus.req_addr   = 32'h20;
    bus.req_wdata  = 32'h12345678;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("abort/req_ready_busy", 32'(bus.req_ready), 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort/req_ready", 32'(bus.req_ready), 32'd1);
    check("abort/rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("abort/rsp_rdata", bus.rsp_rdata, 32'd0);
    check("abort/rsp_err",   32'(bus.rsp_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    xact("lw20b", 1'b0, F3_W, 32'h20, 32'h0, 0, 32'hCAFEF00D, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
